// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern driver: per-channel OFF/ON/BLINK/BREATHE with PWM brightness.
// A shared prescaler produces pattern ticks; a shared free-running counter drives the PWM compare.
module led_pattern_gen #(
  parameter int                  NUM_LEDS     = 4,
  parameter int                  TICK_DIV     = 450000,
  parameter int                  PWM_BITS     = 8,
  parameter int                  PERIOD_W     = 16,
  parameter bit                  ACTIVE_HIGH  = 1'b1,
  parameter int                  RESET_MODE   = 2,
  parameter int                  RESET_PERIOD = 400,
  parameter logic [PWM_BITS-1:0] RESET_DUTY   = '1
) (
  input  logic                osc_clk,
  input  logic                gsrn,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_sel,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PWM_BITS-1:0] cfg_duty,
  input  logic                sync_restart,
  output logic                tick,
  output logic [NUM_LEDS-1:0] led
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam int                  PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_TOP  = '1;
  localparam logic [NUM_LEDS-1:0] INV_MASK = ACTIVE_HIGH ? '0 : '1;
  localparam mode_t               MODE_RST = mode_t'(2'(RESET_MODE));

  logic [PRE_W-1:0]    presc_reg, presc_next;
  logic                tick_reg, tick_next;
  logic [PWM_BITS-1:0] pwm_reg, pwm_next;
  logic [NUM_LEDS-1:0] lit_raw;
  logic [NUM_LEDS-1:0] led_reg;

  // tick is registered so that it is high exactly while the prescaler sits on its last count
  always_comb begin
    presc_next = presc_reg + 1'b1;
    if (sync_restart || (presc_reg == PRE_LAST)) begin
      presc_next = '0;
    end
    tick_next = (presc_next == PRE_LAST);
    pwm_next  = sync_restart ? '0 : pwm_reg + 1'b1;
  end

  always_ff @(posedge osc_clk or negedge gsrn) begin
    if (!gsrn) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
      pwm_reg   <= '0;
      led_reg   <= INV_MASK;
    end else begin
      presc_reg <= presc_next;
      tick_reg  <= tick_next;
      pwm_reg   <= pwm_next;
      led_reg   <= lit_raw ^ INV_MASK;
    end
  end

  assign tick = tick_reg;
  assign led  = led_reg;

  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
      mode_t               mode_reg, mode_next;
      logic [PERIOD_W-1:0] period_reg, period_next;
      logic [PWM_BITS-1:0] duty_reg, duty_next;
      logic [PERIOD_W-1:0] phase_reg, phase_next;
      logic                blink_on_reg, blink_on_next;
      logic [PWM_BITS-1:0] level_reg, level_next;
      logic                dir_down_reg, dir_down_next;
      logic [PERIOD_W-1:0] phase_last;
      logic                wr_sel;
      logic                step;
      logic [PWM_BITS-1:0] eff;

      // cfg_sel values >= NUM_LEDS match no channel, so such writes fall through untouched
      assign wr_sel     = cfg_we && (cfg_sel == 4'(gi));
      assign phase_last = (period_reg == '0) ? '0 : period_reg - 1'b1;
      assign step       = tick_reg && (phase_reg == phase_last);

      always_comb begin
        mode_next     = mode_reg;
        period_next   = period_reg;
        duty_next     = duty_reg;
        phase_next    = phase_reg;
        blink_on_next = blink_on_reg;
        level_next    = level_reg;
        dir_down_next = dir_down_reg;
        if (wr_sel) begin
          mode_next   = mode_t'(cfg_mode);
          period_next = cfg_period;
          duty_next   = cfg_duty;
        end
        // a write or restart realigns the channel and overrides any step due this cycle
        if (wr_sel || sync_restart) begin
          phase_next    = '0;
          blink_on_next = 1'b1;
          level_next    = '0;
          dir_down_next = 1'b0;
        end else if (tick_reg) begin
          phase_next = step ? '0 : phase_reg + 1'b1;
          if (step) begin
            blink_on_next = ~blink_on_reg;
            if (!dir_down_reg) begin
              level_next = level_reg + 1'b1;
              if (level_next == PWM_TOP) dir_down_next = 1'b1;
            end else begin
              level_next = level_reg - 1'b1;
              if (level_next == '0) dir_down_next = 1'b0;
            end
          end
        end
      end

      always_ff @(posedge osc_clk or negedge gsrn) begin
        if (!gsrn) begin
          mode_reg     <= MODE_RST;
          period_reg   <= PERIOD_W'(RESET_PERIOD);
          duty_reg     <= RESET_DUTY;
          phase_reg    <= '0;
          blink_on_reg <= 1'b1;
          level_reg    <= '0;
          dir_down_reg <= 1'b0;
        end else begin
          mode_reg     <= mode_next;
          period_reg   <= period_next;
          duty_reg     <= duty_next;
          phase_reg    <= phase_next;
          blink_on_reg <= blink_on_next;
          level_reg    <= level_next;
          dir_down_reg <= dir_down_next;
        end
      end

      always_comb begin
        eff = '0;
        case (mode_reg)
          MODE_OFF:     eff = '0;
          MODE_ON:      eff = duty_reg;
          MODE_BLINK:   eff = blink_on_reg ? duty_reg : '0;
          MODE_BREATHE: eff = level_reg;
          default:      eff = '0;
        endcase
      end

      // full-scale brightness bypasses the compare so the LED never drops out
      assign lit_raw[gi] = (eff == PWM_TOP) || (pwm_reg < eff);
    end
  endgenerate

endmodule
